seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 84 ++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle.
// Signed operands are multiplied as magnitudes, and the sign is applied when C is loaded.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   C,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     a_mag, b_sh, a_abs, b_abs;
    logic                 neg;
    logic [2*WIDTH-1:0]   acc, acc_nxt, addend;
    logic                 last;

    // Negating 2^(WIDTH-1) in WIDTH bits gives the same bit pattern,
    // which is the correct unsigned magnitude.
    assign a_abs  = (signed_mode && A[WIDTH-1]) ? WIDTH'(-A) : A;
    assign b_abs  = (signed_mode && B[WIDTH-1]) ? WIDTH'(-B) : B;
    assign addend = b_sh[0] ? ((2*WIDTH)'(a_mag) << cnt) : '0;
    assign acc_nxt = acc + addend;
    assign last   = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            acc   <= '0;
            a_mag <= '0;
            b_sh  <= '0;
            neg   <= 1'b0;
            C     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_mag <= a_abs;
                    b_sh  <= b_abs;
                    neg   <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
                RUN: begin
                    acc  <= acc_nxt;
                    cnt  <= cnt + 1'b1;
                    b_sh <= b_sh >> 1;
                    if (last) begin
                        C    <= neg ? (2*WIDTH)'(-acc_nxt) : acc_nxt;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
